// File: rtl/filter_decim_pkg.sv
// rtl/filter_decim_pkg.sv - shared defaults, widths and round/saturate helper for filter_out_decimator
//
// Contents:
//   M_DEF, DECIM_DEF    default sample width and decimation ratio
//   ACC_W, OUT_W        accumulator and output widths for the defaults
//   SAT_MAX, SAT_MIN    output clip limits for the defaults
//   round_sat()         round-half-up, arithmetic shift, saturate; returns value and clip flag
package filter_decim_pkg;

    localparam int M_DEF     = 7;
    localparam int DECIM_DEF = 4;
    localparam int L_DEF     = $clog2(DECIM_DEF);
    localparam int ACC_W     = 2 * M_DEF + L_DEF;
    localparam int OUT_W     = M_DEF;
    localparam int SAT_MAX   = 2 ** (M_DEF - 1) - 1;
    localparam int SAT_MIN   = -(2 ** (M_DEF - 1));

    typedef struct packed {
        logic signed [31:0] val;
        logic               clip;
    } round_sat_t;

    // The sum arrives sign-extended to 64 bits, far wider than 2*M+L+1,
    // so adding the rounding constant can never wrap.
    function automatic round_sat_t round_sat(
        input logic signed [63:0] sum,
        input int                 frac_sh,
        input int                 out_w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        round_sat_t         res;
        r        = (sum + (64'sd1 <<< (frac_sh - 1))) >>> frac_sh;
        hi       = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo       = -(64'sd1 <<< (out_w - 1));
        res.val  = r[31:0];
        res.clip = 1'b0;
        if (r > hi) begin
            res.val  = hi[31:0];
            res.clip = 1'b1;
        end else if (r < lo) begin
            res.val  = lo[31:0];
            res.clip = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/decim_fifo.sv
// rtl/decim_fifo.sv - synchronous first-word-fall-through FIFO for decimated results
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_push       write i_data at the tail (dropped when full unless a pop happens too)
//   i_data       tail write data
//   i_pop        consumer request; ignored while empty
//   o_data       head word; while empty it holds the last word popped (0 after reset)
//   o_empty      no entries
//   o_full       DEPTH entries
//   o_count      occupancy, 0..DEPTH
//   o_drop       push this cycle was discarded
module decim_fifo #(
    parameter int W     = 7,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count,
    output logic          o_drop
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_last;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_drop    = i_push & ~w_do_push;
    assign o_count   = r_count;
    assign o_data    = o_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/filter_out_decimator.sv
// rtl/filter_out_decimator.sv - integrate-and-dump decimator with round/saturate and output FIFO
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   filter_in    signed 2*M-bit filter output, Q(2M)
//   in_valid     filter_in valid this cycle
//   out_data     signed M-bit decimated sample, Q(M), FIFO head
//   out_valid    FIFO not empty
//   out_ready    consumer accepts out_data
//   overflow     sticky: a result was dropped on a full FIFO
//   fifo_count   FIFO occupancy
//   sat_count    (FILTER_OUT_DECIMATOR_SATCNT_EN only) saturating count of clipped blocks
module filter_out_decimator
    import filter_decim_pkg::*;
#(
    parameter int M          = M_DEF,
    parameter int DECIM      = DECIM_DEF,
    parameter int FIFO_DEPTH = 4,
    localparam int L         = $clog2(DECIM),
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [2*M-1:0] filter_in,
    input  logic                 in_valid,
    output logic signed [M-1:0]  out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic [CW-1:0]        fifo_count
`ifdef FILTER_OUT_DECIMATOR_SATCNT_EN
    ,
    output logic [15:0]          sat_count
`endif
);

    localparam int AW_ACC = 2 * M + L;

    logic signed [AW_ACC-1:0] r_acc;
    logic [L-1:0]             r_phase;
    logic signed [M-1:0]      r_stage;
    logic                     r_stage_valid;
    logic                     r_overflow;

    logic signed [AW_ACC-1:0] w_sum;
    logic                     w_dump;
    round_sat_t               w_rs;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic                     w_fifo_drop;
    logic [33-M:0]            w_unused_bits;

    assign w_sum  = r_acc + {{L{filter_in[2*M-1]}}, filter_in};
    assign w_dump = in_valid & (r_phase == L'(DECIM - 1));
    assign w_rs   = round_sat({{(64 - AW_ACC){w_sum[AW_ACC-1]}}, w_sum}, M + L, M);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= '0;
            r_phase       <= '0;
            r_stage       <= '0;
            r_stage_valid <= 1'b0;
        end else begin
            r_stage_valid <= 1'b0;
            if (w_dump) begin
                r_acc         <= '0;
                r_phase       <= '0;
                r_stage       <= w_rs.val[M-1:0];
                r_stage_valid <= 1'b1;
            end else if (in_valid) begin
                r_acc   <= w_sum;
                r_phase <= r_phase + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop) begin
            r_overflow <= 1'b1;
        end
    end

    decim_fifo #(
        .W     (M),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_stage_valid),
        .i_data  (r_stage),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (fifo_count),
        .o_drop  (w_fifo_drop)
    );

    assign out_valid = ~w_fifo_empty;
    assign overflow  = r_overflow;

`ifdef FILTER_OUT_DECIMATOR_SATCNT_EN
    logic [15:0] r_sat_count;

    // Counted at the dump edge, so a clipped block counts even if the FIFO later drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (w_dump && w_rs.clip && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign sat_count     = r_sat_count;
    assign w_unused_bits = {w_rs.val[31:M], 1'b0, w_fifo_full};
`else
    assign w_unused_bits = {w_rs.val[31:M], w_rs.clip, w_fifo_full};
`endif

endmodule

// File: tb/tb_filter_out_decimator.sv
// tb/tb_filter_out_decimator.sv - self-checking bench for filter_out_decimator (M=7, DECIM=4, FIFO_DEPTH=4)
module tb_filter_out_decimator;

    logic               clk;
    logic               rst_n;
    logic signed [13:0] filter_in;
    logic               in_valid;
    logic signed [6:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               overflow;
    logic [2:0]         fifo_count;
`ifdef FILTER_OUT_DECIMATOR_SATCNT_EN
    logic [15:0]        sat_count;
`endif

    filter_out_decimator #(
        .M          (7),
        .DECIM      (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .filter_in  (filter_in),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .fifo_count (fifo_count)
`ifdef FILTER_OUT_DECIMATOR_SATCNT_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [6:0] exp_q [$];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard: every accepted output word is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d, required no output", out_data);
            end else begin
                check("scoreboard", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic put(input int v, input logic vld);
        filter_in = 14'(v);
        in_valid  = vld;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic block(input int v, input int exp, input bit expect_out);
        if (expect_out) exp_q.push_back(7'(exp));
        for (int i = 0; i < 4; i++) put(v, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int budget;
        out_ready = 1'b1;
        budget = 0;
        while (out_valid && budget < 40) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check({name, "_out_valid"}, int'(out_valid), 0);
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    typedef struct {
        int din;
        int exp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{128,   1};
        tbl[1]  = '{64,    1};
        tbl[2]  = '{-64,   0};
        tbl[3]  = '{-192, -1};
        tbl[4]  = '{8191,  63};
        tbl[5]  = '{-8192, -64};
        tbl[6]  = '{0,     0};
        tbl[7]  = '{1000,  8};
        tbl[8]  = '{-1000, -8};
        tbl[9]  = '{8127,  63};
        tbl[10] = '{8128,  63};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        filter_in = '0;
        out_ready = 1'b1;
        idle(3);
        check("reset_out_valid",  int'(out_valid), 0);
        check("reset_out_data",   int'(out_data), 0);
        check("reset_overflow",   int'(overflow), 0);
        check("reset_fifo_count", int'(fifo_count), 0);
        rst_n = 1'b1;
        idle(1);

        // First result: not visible at the dump edge, visible one edge later.
        exp_q.push_back(7'sd1);
        for (int i = 0; i < 4; i++) put(128, 1'b1);
        check("latency_at_dump", int'(out_valid), 0);
        idle(1);
        check("latency_dump_plus1", int'(out_valid), 1);
        idle(3);

        for (int t = 0; t < 11; t++) block(tbl[t].din, tbl[t].exp, 1'b1);
        idle(4);
        check("table_queue_left", exp_q.size(), 0);
        check("table_overflow", int'(overflow), 0);
`ifdef FILTER_OUT_DECIMATOR_SATCNT_EN
        check("sat_count", int'(sat_count), 2);
`endif

        // Gaps mid-block: invalid cycles carry junk that must be ignored.
        exp_q.push_back(7'sd2);
        put(100, 1'b1);
        put(5000, 1'b0);
        put(200, 1'b1);
        put(-3000, 1'b0);
        put(300, 1'b1);
        put(0, 1'b0);
        put(400, 1'b1);
        idle(4);
        check("gap_queue_left", exp_q.size(), 0);

        // Overflow: no consumer, six blocks, last two dropped.
        out_ready = 1'b0;
        for (int b = 0; b < 4; b++) block(128, 1, 1'b1);
        idle(1);
        check("fill_count", int'(fifo_count), 4);
        check("fill_overflow", int'(overflow), 0);
        for (int b = 0; b < 2; b++) block(128, 1, 1'b0);
        idle(2);
        check("ovf_count", int'(fifo_count), 4);
        check("ovf_overflow", int'(overflow), 1);
        drain("ovf_drain");
        check("ovf_count_after_drain", int'(fifo_count), 0);
        check("ovf_sticky", int'(overflow), 1);
        idle(2);
        check("empty_hold_data", int'(out_data), 1);
        check("empty_count_stays", int'(fifo_count), 0);

        // Reset in the middle of a block discards the partial sum.
        put(4000, 1'b1);
        put(4000, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_fifo_count", int'(fifo_count), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_data", int'(out_data), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        block(512, 4, 1'b1);
        idle(3);
        check("midrst_queue_left", exp_q.size(), 0);

        // Full FIFO with push and pop on the same edge: nothing dropped.
        out_ready = 1'b0;
        block(128, 1, 1'b1);
        block(512, 4, 1'b1);
        block(1000, 8, 1'b1);
        block(64, 1, 1'b1);
        idle(1);
        check("full_count", int'(fifo_count), 4);
        block(-1000, -8, 1'b1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("pushpop_count", int'(fifo_count), 4);
        check("pushpop_overflow", int'(overflow), 0);
        drain("pushpop_drain");
        check("final_overflow", int'(overflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_out_decimator.md
Name: filter_out_decimator

Overview:
- Output stage directly downstream of the noise filter `top`; consumes its full-precision signed `filter_out` word (2M bits, Q(2M) fraction).
- Integrates and dumps DECIM consecutive samples, then averages them.
- Rounds and saturates the average back to the M-bit input format (Q(M) fraction).
- Presents results through a small first-word-fall-through FIFO with a valid/ready handshake to the capture/DAC side.

Parameters:
- M, 7, input-sample width; filter input is 2*M bits, output is M bits.
- DECIM, 4, decimation ratio; power of two, 2..64; L = log2(DECIM).
- FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- filter_in  in  2*M  signed filter output, Q(2M) fraction.
- in_valid  in  1  filter_in is a valid sample this cycle; no backpressure upstream.
- out_data  out  M  signed decimated sample, Q(M); FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- overflow  out  1  sticky; a result was dropped because the FIFO was full.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst_n low, async):
  - accumulator, phase counter, stage register and FIFO are cleared.
  - out_valid=0, out_data=0, overflow=0, fifo_count=0.
  - A partial block in progress is discarded; the first sample after reset starts a new block at phase 0.
- Accumulator:
  - Width 2*M+L, signed.
  - Phase counter runs 0..DECIM-1 and advances only when in_valid=1.
  - Phase < DECIM-1: acc <= acc + sext(filter_in).
  - Phase = DECIM-1 (dump): sum = acc + sext(filter_in); acc <= 0; phase <= 0; stage_valid <= 1.
  - in_valid=0: accumulator and phase hold; gaps are allowed mid-block.
- Requantize (combinational on sum, registered into the stage register at the dump edge):
  - r = (sum + 2^(M+L-1)) >>> (M+L), i.e. round half up, arithmetic shift.
  - Saturate r to [-2^(M-1), 2^(M-1)-1]; intermediate width 2*M+L+1, so no wrap is possible.
- Push:
  - Cycle after the dump edge, the stage register is written to the FIFO tail; stage_valid clears unless another dump occurs (only possible when DECIM=... never, since DECIM >= 2).
  - Latency: last sample of a block accepted at edge k gives out_valid=1 after edge k+1 when the FIFO was empty.
- Pop: on out_valid & out_ready, the head advances at the edge.
- FIFO boundaries:
  - Full with push and no pop: the result is dropped, overflow is set (sticky until reset), contents are unchanged.
  - Full with push and pop in the same cycle: both occur, no drop, count unchanged.
  - Empty with out_ready high: no pop; out_data holds its last value (0 after reset).
  - Pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH.

Optional Feature:
- Macro: FILTER_OUT_DECIMATOR_SATCNT_EN.
- Defined:
  - Adds output port sat_count [15:0].
  - It is a saturating counter (sticks at 16'hFFFF) of blocks whose rounded value was clipped.
  - Cleared by reset.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package filter_decim_pkg holds:
  - M/DECIM defaults.
  - Derived widths: ACC_W = 2*M+L, OUT_W = M.
  - Saturation limits SAT_MAX/SAT_MIN.
  - A pure function round_sat(sum) returning the M-bit result plus a clip flag.
- Sub-module decim_fifo: parameterized sync FWFT FIFO with push/pop/full/empty/count and async active-low reset.
- Accumulator, phase counter and stage register stay in the top.

Test Plan (M=7, DECIM=4, FIFO_DEPTH=4; shift 9, round constant 256):
- Constant filter_in=128, in_valid=1, out_ready=1 -> out_data=1 every 4th sample; first out_valid one cycle after the 4th input edge.
- filter_in=64 x4 -> 1 (half rounds up); filter_in=-64 x4 -> 0; filter_in=-192 x4 -> -1.
- filter_in=8191 x4 -> 63 (saturated, sat_count+1 with macro); filter_in=-8192 x4 -> -64 (exact, no clip).
- out_ready=0, 6 blocks of 128 -> fifo_count reaches 4, 5th and 6th dropped, overflow=1; then out_ready=1 -> four 1s drained, out_valid=0, overflow still 1.
- in_valid toggling 1,0,1,0,... with values 100,200,300,400 -> one result: (1000+256)>>9 = 2.
- rst_n low after 2 samples of a block, release, 4 samples of 512 -> out_data=4 (partial discarded), overflow=0, fifo_count=0 during reset.
